// File: rtl/ita_act_pkg.sv
// Shared types for the activation sequencer: activation modes and the N-lane
// requantized vector carried through the datapath.
package ita_act_pkg;

  localparam int unsigned N_LANES = 4;
  localparam int unsigned ELEM_W  = 8;

  typedef enum logic [1:0] {
    IDENTITY = 2'd0,
    RELU     = 2'd1,
    GELU     = 2'd2
  } activation_e;

  typedef logic signed [N_LANES-1:0][ELEM_W-1:0] requant_oup_t;

endpackage

// File: rtl/ita_activation_ctrl.sv
// Activation datapath sequencer: credit-based issue, LAT-deep in-flight tracking, FWFT output FIFO.
// Optional perf counters (stall / backpressure) are built when ITA_ACT_CTRL_PERF_EN is defined.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_IDLE   | waiting for a tile config; cfg_ready_o high
// S_RUN    | issuing vectors while credit remains and rem_q != 0
// S_DRAIN  | last vector issued; waiting for pipe and FIFO to empty
module ita_activation_ctrl
  import ita_act_pkg::*;
#(
  parameter int unsigned LAT        = 2,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned CNT_W      = 16
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               cfg_valid_i,
  output logic               cfg_ready_o,
  input  activation_e        cfg_activation_i,
  input  logic [CNT_W-1:0]   cfg_len_i,
  input  logic               in_valid_i,
  output logic               in_ready_o,
  input  requant_oup_t       in_data_i,
  output requant_oup_t       dp_data_o,
  output activation_e        dp_activation_o,
  input  requant_oup_t       dp_data_i,
  output logic               out_valid_o,
  input  logic               out_ready_i,
  output requant_oup_t       out_data_o,
  output logic               busy_o,
  output logic               done_o
`ifdef ITA_ACT_CTRL_PERF_EN
  ,
  output logic [31:0]        perf_stall_o,
  output logic [31:0]        perf_bp_o
`endif
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int IW = $clog2(LAT + 1);
  localparam int FW = $clog2(FIFO_DEPTH + LAT + 1) + 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  logic [1:0]       state_q;
  logic [CNT_W-1:0] rem_q;
  logic [LAT-1:0]   pipe_q, pipe_d;
  logic [IW-1:0]    inflight_q, inflight_d;
  logic [CW-1:0]    fifo_count_q, count_d;
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic             done_q;
  requant_oup_t     mem_q [FIFO_DEPTH];

  logic          cfg_accept, issue, capture, pop;
  logic [FW-1:0] free;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(FIFO_DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  assign cfg_ready_o = (state_q == S_IDLE);
  assign cfg_accept  = cfg_valid_i && cfg_ready_o;

  // Credit uses registered occupancy only, so a pop frees a slot one cycle later.
  assign free       = FW'(FIFO_DEPTH) - FW'(fifo_count_q) - FW'(inflight_q);
  assign in_ready_o = (state_q == S_RUN) && (free != '0);
  assign issue      = in_valid_i && in_ready_o;
  assign capture    = pipe_q[LAT-1];

  assign out_valid_o = (fifo_count_q != '0);
  assign pop         = out_valid_o && out_ready_i;
  assign out_data_o  = mem_q[rd_ptr_q];
  assign busy_o      = (state_q != S_IDLE);
  assign done_o      = done_q;

  always_comb begin
    pipe_d[0] = issue;
    for (int i = 1; i < LAT; i++) begin
      pipe_d[i] = pipe_q[i-1];
    end
  end

  always_comb begin
    inflight_d = inflight_q;
    if (issue && !capture) begin
      inflight_d = inflight_q + IW'(1);
    end else if (capture && !issue) begin
      inflight_d = inflight_q - IW'(1);
    end
  end

  always_comb begin
    count_d = fifo_count_q;
    if (capture && !pop) begin
      count_d = fifo_count_q + CW'(1);
    end else if (pop && !capture) begin
      count_d = fifo_count_q - CW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q         <= S_IDLE;
      rem_q           <= '0;
      pipe_q          <= '0;
      inflight_q      <= '0;
      fifo_count_q    <= '0;
      wr_ptr_q        <= '0;
      rd_ptr_q        <= '0;
      dp_data_o       <= '0;
      dp_activation_o <= IDENTITY;
      done_q          <= 1'b0;
    end else begin
      done_q       <= 1'b0;
      pipe_q       <= pipe_d;
      inflight_q   <= inflight_d;
      fifo_count_q <= count_d;
      if (capture) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (pop)     rd_ptr_q <= ptr_inc(rd_ptr_q);
      if (issue) begin
        dp_data_o <= in_data_i;
        rem_q     <= rem_q - CNT_W'(1);
      end
      case (state_q)
        S_IDLE: begin
          if (cfg_accept) begin
            dp_activation_o <= cfg_activation_i;
            rem_q           <= cfg_len_i;
            if (cfg_len_i != '0) begin
              state_q <= S_RUN;
            end else begin
              done_q <= 1'b1;
            end
          end
        end
        S_RUN: begin
          if (issue && (rem_q == CNT_W'(1))) state_q <= S_DRAIN;
        end
        S_DRAIN: begin
          // Look at next-cycle occupancy so done_o lands right after the final pop.
          if ((inflight_d == '0) && (count_d == '0)) begin
            state_q <= S_IDLE;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (capture && !rst_i) begin
      mem_q[wr_ptr_q] <= dp_data_i;
    end
  end

`ifdef ITA_ACT_CTRL_PERF_EN
  always_ff @(posedge clk_i) begin
    if (rst_i || cfg_accept) begin
      perf_stall_o <= '0;
      perf_bp_o    <= '0;
    end else begin
      if ((state_q == S_RUN) && in_valid_i && !in_ready_o && (perf_stall_o != '1)) begin
        perf_stall_o <= perf_stall_o + 32'd1;
      end
      if (out_valid_o && !out_ready_i && (perf_bp_o != '1)) begin
        perf_bp_o <= perf_bp_o + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_ita_activation_ctrl.sv
// Scoreboard bench for ita_activation_ctrl: a datapath stub applies the activation,
// the reference queue holds expected results in issue order, a monitor pops on each output.
module tb_ita_activation_ctrl;
  import ita_act_pkg::*;

  localparam int LAT        = 2;
  localparam int FIFO_DEPTH = 4;
  localparam int CNT_W      = 16;

  logic               clk = 1'b0;
  logic               rst;
  logic               cfg_valid;
  logic               cfg_ready;
  activation_e        cfg_activation;
  logic [CNT_W-1:0]   cfg_len;
  logic               in_valid;
  logic               in_ready;
  requant_oup_t       in_data;
  requant_oup_t       dp_data_out;
  activation_e        dp_activation;
  requant_oup_t       dp_data_in;
  logic               out_valid;
  logic               out_ready;
  requant_oup_t       out_data;
  logic               busy;
  logic               done;
`ifdef ITA_ACT_CTRL_PERF_EN
  logic [31:0]        perf_stall;
  logic [31:0]        perf_bp;
`endif

  ita_activation_ctrl #(.LAT(LAT), .FIFO_DEPTH(FIFO_DEPTH), .CNT_W(CNT_W)) dut (
    .clk_i(clk), .rst_i(rst),
    .cfg_valid_i(cfg_valid), .cfg_ready_o(cfg_ready),
    .cfg_activation_i(cfg_activation), .cfg_len_i(cfg_len),
    .in_valid_i(in_valid), .in_ready_o(in_ready), .in_data_i(in_data),
    .dp_data_o(dp_data_out), .dp_activation_o(dp_activation), .dp_data_i(dp_data_in),
    .out_valid_o(out_valid), .out_ready_i(out_ready), .out_data_o(out_data),
    .busy_o(busy), .done_o(done)
`ifdef ITA_ACT_CTRL_PERF_EN
    , .perf_stall_o(perf_stall), .perf_bp_o(perf_bp)
`endif
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int issued = 0;
  int pops = 0;
  int done_cnt = 0;
  int stall_cnt = 0;
  int first_pop = -1;
  int last_pop = -1;
  activation_e cur_mode = IDENTITY;
  requant_oup_t exp_q[$];
  requant_oup_t dp_stage;

  // Reference activation, lane by lane.
  function automatic requant_oup_t act_fn(input activation_e m, input requant_oup_t v);
    requant_oup_t r;
    logic signed [ELEM_W-1:0] x;
    for (int i = 0; i < N_LANES; i++) begin
      x = $signed(v[i]);
      case (m)
        RELU:    r[i] = (x < 0) ? '0 : x;
        GELU:    r[i] = (x < 0) ? (x >>> 2) : x;
        default: r[i] = x;
      endcase
    end
    return r;
  endfunction

  // Datapath stub: dp_data_o is already registered, so one more stage gives LAT=2.
  always @(posedge clk) dp_stage <= act_fn(dp_activation, dp_data_out);
  assign dp_data_in = dp_stage;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: issue pushes the expected result, each pop is compared in order.
  always @(negedge clk) begin
    if (!rst) begin
      if (in_valid && in_ready) begin
        exp_q.push_back(act_fn(cur_mode, in_data));
        issued++;
      end
      if (cfg_valid == 1'b0 && !cfg_ready && in_valid && !in_ready) stall_cnt++;
      if (out_valid && out_ready) begin
        pops++;
        last_pop = cyc;
        if (first_pop < 0) first_pop = cyc;
        if (exp_q.size() == 0) begin
          chk("pop_without_issue", longint'(exp_q.size()), 1);
        end else begin
          chk("out_data", longint'(out_data), longint'(exp_q.pop_front()));
        end
      end
      if (done) done_cnt++;
    end
  end

  task automatic do_cfg(input activation_e m, input int len);
    int k;
    cfg_activation = m;
    cfg_len = CNT_W'(len);
    cfg_valid = 1'b1;
    cur_mode = m;
    k = 0;
    do begin @(negedge clk); k++; end while (!cfg_ready && k < 400);
    if (!cfg_ready) chk("cfg_timeout", cfg_ready, 1);
    @(posedge clk); #1;
    cfg_valid = 1'b0;
  endtask

  task automatic drive_tile(input int n, input int gap_max);
    int k;
    for (int i = 0; i < n; i++) begin
      if (gap_max > 0) begin
        in_valid = 1'b0;
        repeat ($urandom_range(0, gap_max)) begin @(posedge clk); #1; end
      end
      in_data = requant_oup_t'($urandom);
      in_valid = 1'b1;
      k = 0;
      do begin @(negedge clk); k++; end while (!in_ready && k < 400);
      if (!in_ready) begin
        chk("issue_timeout", in_ready, 1);
        in_valid = 1'b0;
        return;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_done(input string nm);
    int k;
    k = 0;
    do begin @(negedge clk); k++; end while (!done && k < 400);
    chk({nm, "_done"}, done, 1);
    chk({nm, "_busy_low"}, busy, 0);
    @(posedge clk); #1;
  endtask

  int t_acc, base_i, base_p, base_d, k, len;
  bit drv_done;

  initial begin
    rst = 1'b1; cfg_valid = 1'b0; cfg_activation = IDENTITY; cfg_len = '0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_cfg_ready", cfg_ready, 1);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_dp_data", longint'(dp_data_out), 0);
    chk("rst_dp_act", dp_activation, IDENTITY);
    @(posedge clk); #1;

    // Single vector, RELU: out_valid three cycles after the accept cycle.
    do_cfg(RELU, 1);
    out_ready = 1'b1;
    in_data = requant_oup_t'($urandom);
    in_valid = 1'b1;
    k = 0;
    do begin @(negedge clk); k++; end while (!in_ready && k < 50);
    chk("single_in_ready", in_ready, 1);
    chk("single_dp_act", dp_activation, RELU);
    t_acc = cyc;
    @(posedge clk); #1;
    in_valid = 1'b0;
    k = 0;
    do begin @(negedge clk); k++; end while (!out_valid && k < 50);
    chk("single_latency", cyc - t_acc, LAT + 1);
    @(negedge clk);
    chk("single_done_after_pop", done, 1);
    chk("single_busy_low", busy, 0);
    @(posedge clk); #1;

    // Streaming: in_ready never drops, outputs back-to-back.
    base_p = pops; base_d = done_cnt; stall_cnt = 0; first_pop = -1;
    do_cfg(GELU, 8);
    drive_tile(8, 0);
    wait_done("stream");
    chk("stream_pops", pops - base_p, 8);
    chk("stream_consecutive", last_pop - first_pop, 7);
    chk("stream_stalls", stall_cnt, 0);
    chk("stream_done_once", done_cnt - base_d, 1);

    // Backpressure: only FIFO_DEPTH vectors accepted while out_ready is low.
    base_i = issued; base_p = pops;
    do_cfg(RELU, 10);
    out_ready = 1'b0;
    fork
      drive_tile(10, 0);
      begin
        repeat (20) @(posedge clk);
        #1;
        chk("bp_accepted", issued - base_i, FIFO_DEPTH);
        @(negedge clk);
        chk("bp_in_ready_low", in_ready, 0);
        @(posedge clk); #1;
        out_ready = 1'b1;
      end
    join
    wait_done("bp");
    chk("bp_pops", pops - base_p, 10);
    chk("bp_queue_empty", exp_q.size(), 0);

    // Zero length: accepted, done next cycle, nothing issued.
    base_i = issued;
    do_cfg(RELU, 0);
    @(negedge clk);
    chk("zero_done", done, 1);
    chk("zero_busy", busy, 0);
    @(negedge clk);
    chk("zero_done_single", done, 0);
    chk("zero_busy_still", busy, 0);
    chk("zero_no_issue", issued - base_i, 0);
    @(posedge clk); #1;

    // Mid-tile reset after 3 issues.
    out_ready = 1'b0;
    do_cfg(GELU, 6);
    drive_tile(3, 0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete();
    @(negedge clk);
    chk("mrst_out_valid", out_valid, 0);
    chk("mrst_busy", busy, 0);
    chk("mrst_cfg_ready", cfg_ready, 1);
    chk("mrst_in_ready", in_ready, 0);
    chk("mrst_dp_data", longint'(dp_data_out), 0);
    chk("mrst_dp_act", dp_activation, IDENTITY);
    @(posedge clk); #1;
    base_p = pops;
    out_ready = 1'b1;
    do_cfg(IDENTITY, 2);
    drive_tile(2, 0);
    wait_done("mrst_retile");
    chk("mrst_retile_pops", pops - base_p, 2);

    // Full FIFO: a single pop frees credit only from the following cycle.
    base_i = issued; base_p = pops;
    out_ready = 1'b0;
    do_cfg(IDENTITY, 5);
    fork
      drive_tile(5, 0);
      begin
        repeat (12) @(posedge clk);
        #1;
        chk("full_accepted", issued - base_i, FIFO_DEPTH);
        @(negedge clk);
        chk("full_out_valid", out_valid, 1);
        chk("full_in_ready_low", in_ready, 0);
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(negedge clk);
        chk("full_credit_lag", in_ready, 0);
        @(posedge clk); #1;
        out_ready = 1'b0;
        @(negedge clk);
        chk("full_credit_back", in_ready, 1);
        repeat (6) @(posedge clk);
        #1;
        chk("full_accepted_5", issued - base_i, 5);
        out_ready = 1'b1;
      end
    join
    wait_done("full");
    chk("full_pops", pops - base_p, 5);

    // Randomized tiles with input gaps and random downstream readiness.
    for (int r = 0; r < 5; r++) begin
      base_p = pops;
      len = $urandom_range(1, 12);
      do_cfg(activation_e'($urandom_range(0, 2)), len);
      drv_done = 1'b0;
      fork
        begin drive_tile(len, 3); drv_done = 1'b1; end
        while (!drv_done) begin @(posedge clk); #1; out_ready = $urandom_range(0, 1) != 0; end
      join
      out_ready = 1'b1;
      wait_done("rand");
      chk("rand_pops", pops - base_p, len);
      chk("rand_queue_empty", exp_q.size(), 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", n_chk);
    $fatal(1, "watchdog");
  end

endmodule
